// File: rtl/irq_gateway_pkg.sv
// Shared definitions for the interrupt gateway: register map, per-source FSM
// encoding, CSR addresses and the claim priority helper.
package irq_gateway_pkg;

  // Per-source gateway state
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_CLAIMED = 2'd2
  } src_state_e;

  // Bus register byte offsets
  localparam logic [3:0] REG_PENDING  = 4'h0;
  localparam logic [3:0] REG_EDGE_CFG = 4'h4;
  localparam logic [3:0] REG_CLAIM    = 4'h8;
  localparam logic [3:0] REG_COMPLETE = 4'hC;

  // CSR block addresses that consume o_MEI
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int unsigned MAX_SRC = 32;

  // Returns (index + 1) of the lowest set bit, or 0 when no bit is set.
  function automatic logic [7:0] first_set(input logic [MAX_SRC-1:0] vec);
    first_set = '0;
    for (int unsigned i = MAX_SRC; i > 0; i--) begin
      if (vec[i-1]) first_set = 8'(i);
    end
  endfunction

endpackage

// File: rtl/irq_src_cell.sv
// One interrupt source: synchronizer, edge detect, gateway FSM and the
// one-deep edge latch that remembers a rise seen while claimed.
module irq_src_cell
  import irq_gateway_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic edge_mode,
  input  logic claim,
  input  logic complete,
  output logic pending
);

  logic       sync_1;
  logic       sync_2;
  logic       lvl_q;
  logic       prev_q;
  logic       edge_latch;
  logic       rise;
  logic       trigger;
  src_state_e state;

  // lvl_q/prev_q are cleared by reset, so a flushed chain cannot produce a rise
  assign rise    = lvl_q & ~prev_q;
  assign trigger = edge_mode ? rise : lvl_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      lvl_q      <= 1'b0;
      prev_q     <= 1'b0;
      edge_latch <= 1'b0;
      state      <= ST_IDLE;
      pending    <= 1'b0;
    end else begin
      sync_1 <= src;
      sync_2 <= sync_1;
      lvl_q  <= sync_2;
      prev_q <= lvl_q;
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state   <= ST_PENDING;
            pending <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (claim) begin
            state   <= ST_CLAIMED;
            pending <= 1'b0;
          end
        end
        ST_CLAIMED: begin
          if (complete) begin
            // a latched or coincident rise re-pends instead of going idle
            edge_latch <= 1'b0;
            if (edge_mode && (edge_latch || rise)) begin
              state   <= ST_PENDING;
              pending <= 1'b1;
            end else begin
              state   <= ST_IDLE;
              pending <= 1'b0;
            end
          end else if (edge_mode && rise) begin
            edge_latch <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/irq_gateway.sv
// Interrupt gateway top: EDGE_CFG register, bus decode, claim priority and
// registered read data around N_SRC per-source cells.
module irq_gateway
  import irq_gateway_pkg::*;
#(
  parameter int unsigned N_SRC = 6
) (
  input  logic             i_CLK,
  input  logic             i_RSTn,
  input  logic [N_SRC-1:0] i_SRC,
  input  logic             i_BUS_EN,
  input  logic             i_BUS_WE,
  input  logic [3:0]       i_BUS_ADDR,
  input  logic [31:0]      i_BUS_WDATA,
  output logic [31:0]      o_BUS_RDATA,
  output logic             o_BUS_ACK,
  output logic [N_SRC-1:0] o_MEI
);

  logic [N_SRC-1:0]   edge_cfg;
  logic [N_SRC-1:0]   pending;
  logic [N_SRC-1:0]   claim_sel;
  logic [N_SRC-1:0]   complete_sel;
  logic [MAX_SRC-1:0] pending_word;
  logic [7:0]         claim_id;
  logic [31:0]        rdata_next;
  logic               rd;
  logic               wr;
  logic               claim_rd;
  logic               complete_wr;
  logic               unused_wdata;

  assign rd           = i_BUS_EN & ~i_BUS_WE;
  assign wr           = i_BUS_EN & i_BUS_WE;
  assign claim_rd     = rd && (i_BUS_ADDR == REG_CLAIM);
  assign complete_wr  = wr && (i_BUS_ADDR == REG_COMPLETE);
  assign pending_word = MAX_SRC'(pending);
  assign claim_id     = first_set(pending_word);
  assign unused_wdata = &{1'b0, i_BUS_WDATA};

  // Claim uses pre-edge pending state; IDs 0 and > N_SRC match no source
  always_comb begin
    claim_sel    = '0;
    complete_sel = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      claim_sel[k]    = claim_rd && (claim_id == 8'(k + 1));
      complete_sel[k] = complete_wr && (i_BUS_WDATA[7:0] == 8'(k + 1));
    end
  end

  always_comb begin
    rdata_next = '0;
    if (rd) begin
      case (i_BUS_ADDR)
        REG_PENDING:  rdata_next = 32'(pending_word);
        REG_EDGE_CFG: rdata_next = 32'(edge_cfg);
        REG_CLAIM:    rdata_next = 32'(claim_id);
        default:      rdata_next = '0;
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      edge_cfg    <= '0;
      o_BUS_ACK   <= 1'b0;
      o_BUS_RDATA <= '0;
    end else begin
      o_BUS_ACK   <= i_BUS_EN;
      o_BUS_RDATA <= rdata_next;
      if (wr && (i_BUS_ADDR == REG_EDGE_CFG)) begin
        edge_cfg <= i_BUS_WDATA[N_SRC-1:0];
      end
    end
  end

  for (genvar k = 0; k < N_SRC; k++) begin : g_src
    irq_src_cell u_cell (
      .clk       (i_CLK),
      .rst_n     (i_RSTn),
      .src       (i_SRC[k]),
      .edge_mode (edge_cfg[k]),
      .claim     (claim_sel[k]),
      .complete  (complete_sel[k]),
      .pending   (pending[k])
    );
  end

  assign o_MEI = pending;

endmodule

// File: tb/tb_irq_gateway.sv
// Directed self-checking bench for irq_gateway.
module tb_irq_gateway;

  logic        clk;
  logic        rst_n;
  logic [5:0]  src;
  logic        bus_en;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [5:0]  mei;

  int checks   = 0;
  int failures = 0;

  irq_gateway #(.N_SRC(6)) dut (
    .i_CLK       (clk),
    .i_RSTn      (rst_n),
    .i_SRC       (src),
    .i_BUS_EN    (bus_en),
    .i_BUS_WE    (bus_we),
    .i_BUS_ADDR  (bus_addr),
    .i_BUS_WDATA (bus_wdata),
    .o_BUS_RDATA (bus_rdata),
    .o_BUS_ACK   (bus_ack),
    .o_MEI       (mei)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = a; bus_wdata = '0;
    @(posedge clk); #1;
    bus_en = 1'b0;
    checks++;
    if (bus_ack !== 1'b1) begin
      failures++;
      $display("FAIL read_ack addr=%0h got=%b exp=1", a, bus_ack);
    end
    d = bus_rdata;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] wd);
    bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = wd;
    @(posedge clk); #1;
    bus_en = 1'b0; bus_we = 1'b0;
    checks++;
    if (bus_ack !== 1'b1) begin
      failures++;
      $display("FAIL write_ack addr=%0h got=%b exp=1", a, bus_ack);
    end
    checks++;
    if (bus_rdata !== 32'h0) begin
      failures++;
      $display("FAIL write_rdata addr=%0h got=%0h exp=0", a, bus_rdata);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0; src = '0; bus_en = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    tick(3);
    checks++;
    if (bus_ack !== 1'b0 || bus_rdata !== 32'h0 || mei !== 6'h0) begin
      failures++;
      $display("FAIL reset_outputs got ack=%b rdata=%0h mei=%0h exp 0/0/0", bus_ack, bus_rdata, mei);
    end
    rst_n = 1'b1;
    tick(1);
    bus_read(4'h0, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_pending got=%0h exp=0", d); end
    bus_read(4'h4, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_edgecfg got=%0h exp=0", d); end
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_claim got=%0h exp=0", d); end
    tick(1);
    checks++;
    if (bus_ack !== 1'b0 || bus_rdata !== 32'h0) begin
      failures++;
      $display("FAIL idle_bus got ack=%b rdata=%0h exp 0/0", bus_ack, bus_rdata);
    end
  endtask

  task automatic test_level();
    logic [31:0] d;
    src[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if (mei !== 6'h00) begin failures++; $display("FAIL level_latency edge=%0d got=%0h exp=0", i, mei); end
    end
    tick(1);
    checks++;
    if (mei !== 6'h04) begin failures++; $display("FAIL level_pend got=%0h exp=04", mei); end
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'd3) begin failures++; $display("FAIL level_claim got=%0d exp=3", d); end
    checks++;
    if (mei !== 6'h00) begin failures++; $display("FAIL level_claimed_mei got=%0h exp=0", mei); end
  endtask

  task automatic test_level_rearm();
    logic [31:0] d;
    bus_write(4'hC, 32'd3);
    checks++;
    if (mei !== 6'h00) begin failures++; $display("FAIL rearm_idle got=%0h exp=0", mei); end
    tick(1);
    checks++;
    if (mei !== 6'h04) begin failures++; $display("FAIL rearm_pend got=%0h exp=04", mei); end
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'd3) begin failures++; $display("FAIL rearm_claim got=%0d exp=3", d); end
    bus_write(4'hC, 32'd7);
    bus_write(4'hC, 32'd0);
    tick(2);
    checks++;
    if (mei !== 6'h00) begin failures++; $display("FAIL complete_bad_id got=%0h exp=0", mei); end
    src[2] = 1'b0;
    tick(4);
    bus_write(4'hC, 32'd3);
    tick(2);
    checks++;
    if (mei !== 6'h00) begin failures++; $display("FAIL level_release got=%0h exp=0", mei); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    src = 6'h21;
    tick(5);
    checks++;
    if (mei !== 6'h21) begin failures++; $display("FAIL prio_mei got=%0h exp=21", mei); end
    // back-to-back accesses, bus_en held high across all of them
    bus_read(4'h0, d);
    checks++;
    if (d !== 32'h21) begin failures++; $display("FAIL prio_pend0 got=%0h exp=21", d); end
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL prio_claim0 got=%0d exp=1", d); end
    bus_read(4'h0, d);
    checks++;
    if (d !== 32'h20) begin failures++; $display("FAIL prio_pend1 got=%0h exp=20", d); end
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'd6) begin failures++; $display("FAIL prio_claim1 got=%0d exp=6", d); end
    bus_read(4'h0, d);
    checks++;
    if (d !== 32'h00) begin failures++; $display("FAIL prio_pend2 got=%0h exp=0", d); end
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL prio_claim2 got=%0d exp=0", d); end
    src = '0;
    tick(4);
    bus_write(4'hC, 32'd1);
    bus_write(4'hC, 32'd6);
    tick(2);
    checks++;
    if (mei !== 6'h00) begin failures++; $display("FAIL prio_release got=%0h exp=0", mei); end
  endtask

  task automatic pulse(input int idx, input int low_cycles);
    src[idx] = 1'b1;
    tick(2);
    src[idx] = 1'b0;
    tick(low_cycles);
  endtask

  task automatic test_edge();
    logic [31:0] d;
    bus_write(4'h4, 32'h02);
    bus_read(4'h4, d);
    checks++;
    if (d !== 32'h02) begin failures++; $display("FAIL edgecfg_rd got=%0h exp=02", d); end
    pulse(1, 6);
    checks++;
    if (mei !== 6'h02) begin failures++; $display("FAIL edge_pend got=%0h exp=02", mei); end
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'd2) begin failures++; $display("FAIL edge_claim0 got=%0d exp=2", d); end
    pulse(1, 4);
    pulse(1, 5);
    checks++;
    if (mei !== 6'h00) begin failures++; $display("FAIL edge_held got=%0h exp=0", mei); end
    bus_write(4'hC, 32'd2);
    checks++;
    if (mei !== 6'h02) begin failures++; $display("FAIL edge_repend got=%0h exp=02", mei); end
    pulse(1, 5);
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'd2) begin failures++; $display("FAIL edge_claim1 got=%0d exp=2", d); end
    bus_write(4'hC, 32'd2);
    tick(2);
    checks++;
    if (mei !== 6'h00) begin failures++; $display("FAIL edge_idle got=%0h exp=0", mei); end
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL edge_claim2 got=%0d exp=0", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    bus_write(4'h0, 32'hFFFF_FFFF);
    bus_write(4'h8, 32'hFFFF_FFFF);
    bus_write(4'h2, 32'hFFFF_FFFF);
    bus_read(4'hD, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL unmapped_rd got=%0h exp=0", d); end
    bus_read(4'hC, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL complete_rd got=%0h exp=0", d); end
    bus_read(4'h0, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL pending_ro got=%0h exp=0", d); end
    bus_read(4'h4, d);
    checks++;
    if (d !== 32'h02) begin failures++; $display("FAIL edgecfg_kept got=%0h exp=02", d); end
  endtask

  task automatic test_reset_claimed();
    logic [31:0] d;
    bus_write(4'h4, 32'hFFFF_FFFF);
    bus_read(4'h4, d);
    checks++;
    if (d !== 32'h3F) begin failures++; $display("FAIL edgecfg_mask got=%0h exp=3f", d); end
    pulse(4, 5);
    checks++;
    if (mei !== 6'h10) begin failures++; $display("FAIL rst_pre_pend got=%0h exp=10", mei); end
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'd5) begin failures++; $display("FAIL rst_pre_claim got=%0d exp=5", d); end
    // reset lands on an in-flight claim read
    rst_n = 1'b0; bus_en = 1'b1; bus_we = 1'b0; bus_addr = 4'h8;
    tick(1);
    rst_n = 1'b1; bus_en = 1'b0;
    checks++;
    if (bus_ack !== 1'b0 || bus_rdata !== 32'h0 || mei !== 6'h0) begin
      failures++;
      $display("FAIL rst_abort got ack=%b rdata=%0h mei=%0h exp 0/0/0", bus_ack, bus_rdata, mei);
    end
    bus_write(4'h4, 32'h10);
    tick(4);
    checks++;
    if (mei !== 6'h00) begin failures++; $display("FAIL rst_no_spurious got=%0h exp=0", mei); end
    bus_read(4'h0, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rst_pending got=%0h exp=0", d); end
    bus_read(4'h8, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL rst_claim got=%0d exp=0", d); end
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    bus_read(4'h4, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rst_edgecfg got=%0h exp=0", d); end
  endtask

  initial begin
    test_reset();
    test_level();
    test_level_rearm();
    test_priority();
    test_edge();
    test_unmapped();
    test_reset_claimed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
